// File: rtl/event_readout_ctrl.sv
// event_readout_ctrl: drains one buffered event per outstanding trigger and frames it as header/payload/trailer on a valid/ready stream.
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   live_rising        run-start pulse, synchronous clear of state and counters
//   n_trig             accepted-trigger count; pending = n_trig - global_n_read
//   evt_nword          payload words per event, latched when an event starts
//   buf_rd_en/buf_data/buf_empty  event buffer read port (data one cycle after strobe)
//   tx_data/tx_valid/tx_last/tx_ready  output stream
//   global_n_read      count of fully transmitted events
//   read_active        high whenever not idle
//   underflow          sticky flag: buffer empty while payload was owed
module event_readout_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int NW_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              live_rising,
  input  logic [CNT_W-1:0]  n_trig,
  input  logic [NW_W-1:0]   evt_nword,
  output logic              buf_rd_en,
  input  logic [DATA_W-1:0] buf_data,
  input  logic              buf_empty,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              tx_last,
  input  logic              tx_ready,
  output logic [CNT_W-1:0]  global_n_read,
  output logic              read_active,
  output logic              underflow
);
  typedef enum logic [2:0] {IDLE, HDR, FETCH, LOAD, SEND, TRL} state_e;
  state_e state_q;
  logic [NW_W-1:0] nw_q, idx_q;
  logic [15:0] xor_q, xor_d;
  logic [DATA_W-1:0] tx_data_q;
  logic tx_valid_q, tx_last_q, underflow_q;
  logic [CNT_W-1:0] n_read_q, pending;
  assign pending = n_trig - n_read_q;
  assign xor_d = xor_q ^ buf_data[31:16] ^ buf_data[15:0];
  // The strobe is combinational so the word arrives during LOAD, giving 3 cycles per payload word.
  assign buf_rd_en = state_q == FETCH && !buf_empty && !live_rising;
  assign tx_data = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last = tx_last_q;
  assign global_n_read = n_read_q;
  assign read_active = state_q != IDLE;
  assign underflow = underflow_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      nw_q <= '0;
      idx_q <= '0;
      xor_q <= '0;
      tx_data_q <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q <= 1'b0;
      n_read_q <= '0;
      underflow_q <= 1'b0;
    end else if (live_rising) begin
      state_q <= IDLE;
      tx_valid_q <= 1'b0;
      tx_last_q <= 1'b0;
      n_read_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (pending != '0) begin
          nw_q <= evt_nword;
          idx_q <= '0;
          xor_q <= '0;
          tx_data_q <= {16'hEB90, n_read_q};
          tx_valid_q <= 1'b1;
          state_q <= HDR;
        end
        HDR: if (tx_ready) begin
          if (nw_q != '0) begin
            tx_valid_q <= 1'b0;
            state_q <= FETCH;
          end else begin
            tx_data_q <= {16'hE0E0, xor_q};
            tx_last_q <= 1'b1;
            state_q <= TRL;
          end
        end
        FETCH: if (buf_empty) underflow_q <= 1'b1;
               else state_q <= LOAD;
        LOAD: begin
          tx_data_q <= buf_data;
          xor_q <= xor_d;
          tx_valid_q <= 1'b1;
          state_q <= SEND;
        end
        SEND: if (tx_ready) begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == nw_q - 1'b1) begin
            tx_data_q <= {16'hE0E0, xor_q};
            tx_last_q <= 1'b1;
            state_q <= TRL;
          end else begin
            tx_valid_q <= 1'b0;
            state_q <= FETCH;
          end
        end
        TRL: if (tx_ready) begin
          tx_valid_q <= 1'b0;
          tx_last_q <= 1'b0;
          n_read_q <= n_read_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_event_readout_ctrl.sv
// tb_event_readout_ctrl: directed bench for event_readout_ctrl with a buffer model and stream monitor.
module tb_event_readout_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, live_rising = 1'b0, tx_ready = 1'b0, hold_empty = 1'b0;
  logic [15:0] n_trig = '0;
  logic [7:0] evt_nword = '0;
  logic buf_rd_en, buf_empty, tx_valid, tx_last, read_active, underflow;
  logic [31:0] buf_data = '0, tx_data;
  logic [15:0] global_n_read;
  logic [31:0] mem [0:31];
  int wp = 0, rp = 0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] words[$];
  logic lasts[$];
  logic [31:0] exp_w[$];
  logic exp_l[$];
  int rd_cnt = 0, act_cnt = 0, rd_bad = 0, stab_err = 0;
  logic [15:0] gnr_at_trl = '0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  int base, r0, a0, s0;

  event_readout_ctrl dut (
    .clk(clk), .rst_n(rst_n), .live_rising(live_rising), .n_trig(n_trig),
    .evt_nword(evt_nword), .buf_rd_en(buf_rd_en), .buf_data(buf_data),
    .buf_empty(buf_empty), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(tx_ready), .global_n_read(global_n_read),
    .read_active(read_active), .underflow(underflow)
  );

  always #5 clk = ~clk;

  assign buf_empty = hold_empty || (rp == wp);
  always @(posedge clk) if (buf_rd_en) begin
    buf_data <= mem[rp];
    rp <= rp + 1;
  end

  always @(negedge clk) begin
    if (tx_valid && tx_ready && !live_rising) begin
      words.push_back(tx_data);
      lasts.push_back(tx_last);
      if (tx_last) gnr_at_trl = global_n_read;
    end
    if (buf_rd_en) rd_cnt++;
    if (buf_rd_en && buf_empty) rd_bad++;
    if (read_active) act_cnt++;
    if (prev_stall && (!tx_valid || tx_data !== prev_data)) stab_err++;
    prev_stall = tx_valid && !tx_ready && !live_rising;
    prev_data = tx_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    mem[wp] = w;
    wp++;
  endtask

  task automatic expect_word(input logic [31:0] w, input logic l);
    exp_w.push_back(w);
    exp_l.push_back(l);
  endtask

  task automatic chk_stream(input string tag, input int b);
    chk({tag, "_len"}, 32'(words.size() - b), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) if (b + i < words.size()) begin
      chk($sformatf("%s_word%0d", tag, i), words[b + i], exp_w[i]);
      chk($sformatf("%s_last%0d", tag, i), 32'(lasts[b + i]), 32'(exp_l[i]));
    end
    exp_w.delete();
    exp_l.delete();
  endtask

  task automatic run_until(input string tag, input logic [15:0] tgt, input bit rnd);
    int k = 0;
    while (!(global_n_read === tgt && !read_active) && k < 3000) begin
      step(1);
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      k++;
    end
    chk({tag, "_done"}, 32'(k < 3000), 32'd1);
    tx_ready = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_last", 32'(tx_last), 0);
    chk("rst_rd_en", 32'(buf_rd_en), 0);
    chk("rst_active", 32'(read_active), 0);
    chk("rst_gnr", 32'(global_n_read), 0);
    chk("rst_underflow", 32'(underflow), 0);
    chk("rst_data", tx_data, 0);
    step(2);
    rst_n = 1'b1;
    step(10);
    chk("idle_active", 32'(read_active), 0);
    chk("idle_valid", 32'(tx_valid), 0);
    chk("idle_gnr", 32'(global_n_read), 0);
    chk("idle_rd", 32'(rd_cnt), 0);

    push(32'h11112222); push(32'h33334444); push(32'h55556666);
    evt_nword = 8'd3;
    tx_ready = 1'b1;
    base = words.size(); r0 = rd_cnt; a0 = act_cnt;
    n_trig = 16'd1;
    run_until("evA", 16'd1, 1'b0);
    expect_word(32'hEB900000, 0); expect_word(32'h11112222, 0); expect_word(32'h33334444, 0);
    expect_word(32'h55556666, 0); expect_word(32'hE0E07777, 1);
    chk_stream("evA", base);
    chk("evA_rd_pulses", 32'(rd_cnt - r0), 3);
    chk("evA_active_cycles", 32'(act_cnt - a0), 11);
    chk("evA_gnr_at_trailer", 32'(gnr_at_trl), 0);
    chk("evA_gnr", 32'(global_n_read), 1);

    push(32'h11112222); push(32'h33334444); push(32'h55556666);
    base = words.size(); r0 = rd_cnt; s0 = stab_err;
    n_trig = 16'd2;
    run_until("evB", 16'd2, 1'b1);
    expect_word(32'hEB900001, 0); expect_word(32'h11112222, 0); expect_word(32'h33334444, 0);
    expect_word(32'h55556666, 0); expect_word(32'hE0E07777, 1);
    chk_stream("evB", base);
    chk("evB_stable", 32'(stab_err - s0), 0);
    chk("evB_rd_pulses", 32'(rd_cnt - r0), 3);

    live_rising = 1'b1; n_trig = '0;
    step(1);
    live_rising = 1'b0;
    chk("clr_gnr", 32'(global_n_read), 0);
    evt_nword = 8'd0;
    base = words.size(); r0 = rd_cnt;
    n_trig = 16'd2;
    run_until("evC", 16'd2, 1'b0);
    expect_word(32'hEB900000, 0); expect_word(32'hE0E00000, 1);
    expect_word(32'hEB900001, 0); expect_word(32'hE0E00000, 1);
    chk_stream("evC", base);
    chk("evC_rd_pulses", 32'(rd_cnt - r0), 0);
    chk("evC_gnr", 32'(global_n_read), 2);

    n_trig = 16'hFFFF;
    force dut.n_read_q = 16'hFFFF;
    step(2);
    release dut.n_read_q;
    step(2);
    chk("wrap_preload", 32'(global_n_read), 32'h0000FFFF);
    chk("wrap_preload_idle", 32'(read_active), 0);
    base = words.size();
    n_trig = 16'h0000;
    run_until("evD", 16'h0000, 1'b0);
    expect_word(32'hEB90FFFF, 0); expect_word(32'hE0E00000, 1);
    chk_stream("evD", base);
    step(10);
    chk("wrap_gnr", 32'(global_n_read), 0);
    chk("wrap_idle", 32'(read_active), 0);

    evt_nword = 8'd2;
    hold_empty = 1'b1;
    base = words.size(); r0 = rd_cnt;
    n_trig = 16'd1;
    step(8);
    chk("uf_flag", 32'(underflow), 1);
    chk("uf_active", 32'(read_active), 1);
    chk("uf_no_rd", 32'(rd_cnt - r0), 0);
    chk("uf_valid", 32'(tx_valid), 0);
    push(32'hDEADBEEF); push(32'h12345678);
    hold_empty = 1'b0;
    run_until("evE", 16'd1, 1'b0);
    expect_word(32'hEB900000, 0); expect_word(32'hDEADBEEF, 0);
    expect_word(32'h12345678, 0); expect_word(32'hE0E0240E, 1);
    chk_stream("evE", base);
    chk("uf_sticky", 32'(underflow), 1);
    live_rising = 1'b1; n_trig = '0;
    step(1);
    live_rising = 1'b0;
    chk("uf_cleared", 32'(underflow), 0);
    chk("uf_gnr_cleared", 32'(global_n_read), 0);

    push(32'hCAFE0001); push(32'hCAFE0002);
    r0 = rd_cnt; a0 = 0;
    n_trig = 16'd1;
    while (rd_cnt == r0 && a0 < 50) begin step(1); a0++; end
    chk("ab_fetch_seen", 32'(a0 < 50), 1);
    tx_ready = 1'b0;
    step(1);
    chk("ab_send_valid", 32'(tx_valid), 1);
    chk("ab_send_last", 32'(tx_last), 0);
    chk("ab_send_data", tx_data, 32'hCAFE0001);
    live_rising = 1'b1; n_trig = '0;
    step(1);
    live_rising = 1'b0;
    chk("ab_valid_drop", 32'(tx_valid), 0);
    chk("ab_idle", 32'(read_active), 0);
    chk("ab_gnr", 32'(global_n_read), 0);
    step(5);
    chk("ab_stay_idle", 32'(read_active), 0);
    chk("rd_never_empty", 32'(rd_bad), 0);
    chk("stable_total", 32'(stab_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
